// File: rtl/wb_stage.sv
// Write-back stage: retires instructions leaving MEM/WB, aligns/extends load data,
// and stalls upstream while a load response is outstanding (with a timeout guard).
module wb_stage #(
    parameter int RSP_TIMEOUT = 255,
    parameter int XLEN        = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic [4:0]      rd_waddr_i,
    input  logic            reg_wen_i,
    input  logic            is_load_i,
    input  logic [2:0]      load_funct3_i,
    input  logic [2:0]      load_offset_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    output logic            stall_o,
    output logic            rf_wen_o,
    output logic [4:0]      rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            retire_valid_o,
    output logic [XLEN-1:0] retire_pc_o,
    output logic [XLEN-1:0] instret_o,
    output logic            timeout_o
);

    typedef enum logic {IDLE = 1'b0, WAIT_RSP = 1'b1} state_t;

    localparam logic [15:0] CNT_LAST = 16'(RSP_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_cnt;
    logic [4:0]        r_rd;
    logic              r_wen;
    logic [XLEN-1:0]   r_pc;
    logic [2:0]        r_funct3;
    logic [2:0]        r_offset;

    logic              w_retire;
    logic              w_wen;
    logic [4:0]        w_waddr;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_pc;
    logic              w_capture;
    logic              w_timeout;
    logic              w_cnt_last;

    // Shift the response word down to the load's byte, then size/extend by funct3.
    function automatic logic [XLEN-1:0] f_ext(input logic [XLEN-1:0] data,
                                              input logic [2:0] funct3,
                                              input logic [2:0] offset);
        logic [XLEN-1:0] s;
        s = data >> {offset, 3'b000};
        case (funct3)
            3'b000:  f_ext = {{(XLEN-8){s[7]}}, s[7:0]};
            3'b001:  f_ext = {{(XLEN-16){s[15]}}, s[15:0]};
            3'b010:  f_ext = {{(XLEN-32){s[31]}}, s[31:0]};
            3'b100:  f_ext = {{(XLEN-8){1'b0}}, s[7:0]};
            3'b101:  f_ext = {{(XLEN-16){1'b0}}, s[15:0]};
            3'b110:  f_ext = {{(XLEN-32){1'b0}}, s[31:0]};
            default: f_ext = s;
        endcase
    endfunction

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (valid_i && is_load_i && !mem_rsp_valid_i) begin
                    w_state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i || w_cnt_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_o   = 1'b0;
        w_retire  = 1'b0;
        w_wen     = 1'b0;
        w_waddr   = '0;
        w_wdata   = '0;
        w_pc      = '0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    if (!is_load_i) begin
                        w_retire = 1'b1;
                        w_wen    = reg_wen_i;
                        w_waddr  = rd_waddr_i;
                        w_wdata  = alu_wdata_i;
                        w_pc     = inst_addr_i;
                    end else if (mem_rsp_valid_i) begin
                        w_retire = 1'b1;
                        w_wen    = reg_wen_i;
                        w_waddr  = rd_waddr_i;
                        w_wdata  = f_ext(mem_rsp_data_i, load_funct3_i, load_offset_i);
                        w_pc     = inst_addr_i;
                    end else begin
                        w_capture = 1'b1;
                        stall_o   = 1'b1;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid_i) begin
                    w_retire = 1'b1;
                    w_wen    = r_wen;
                    w_waddr  = r_rd;
                    w_wdata  = f_ext(mem_rsp_data_i, r_funct3, r_offset);
                    w_pc     = r_pc;
                end else if (w_cnt_last) begin
                    // Abandoned load still retires so instret stays consistent, but writes nothing.
                    w_retire  = 1'b1;
                    w_timeout = 1'b1;
                    w_waddr   = r_rd;
                    w_pc      = r_pc;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rd     <= '0;
            r_wen    <= 1'b0;
            r_pc     <= '0;
            r_funct3 <= '0;
            r_offset <= '0;
        end else if (w_capture) begin
            r_cnt    <= '0;
            r_rd     <= rd_waddr_i;
            r_wen    <= reg_wen_i;
            r_pc     <= inst_addr_i;
            r_funct3 <= load_funct3_i;
            r_offset <= load_offset_i;
        end else if (r_state == WAIT_RSP && !mem_rsp_valid_i && !w_cnt_last) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen_o       <= 1'b0;
            rf_waddr_o     <= '0;
            rf_wdata_o     <= '0;
            retire_valid_o <= 1'b0;
            retire_pc_o    <= '0;
            instret_o      <= '0;
            timeout_o      <= 1'b0;
        end else begin
            rf_wen_o       <= w_retire && w_wen && (w_waddr != 5'd0);
            retire_valid_o <= w_retire;
            if (w_retire) begin
                rf_waddr_o  <= w_waddr;
                rf_wdata_o  <= w_wdata;
                retire_pc_o <= w_pc;
                instret_o   <= instret_o + 1'b1;
            end
            if (w_timeout) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for single-cycle retirements plus
// hand-written delayed-load, timeout and reset-during-wait sequences.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [63:0] inst_addr_i;
    logic [4:0]  rd_waddr_i;
    logic        reg_wen_i;
    logic        is_load_i;
    logic [2:0]  load_funct3_i;
    logic [2:0]  load_offset_i;
    logic [63:0] alu_wdata_i;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_data_i;
    logic        stall_o;
    logic        rf_wen_o;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        retire_valid_o;
    logic [63:0] retire_pc_o;
    logic [63:0] instret_o;
    logic        timeout_o;

    wb_stage #(.RSP_TIMEOUT(4), .XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .inst_addr_i(inst_addr_i), .rd_waddr_i(rd_waddr_i),
        .reg_wen_i(reg_wen_i), .is_load_i(is_load_i), .load_funct3_i(load_funct3_i),
        .load_offset_i(load_offset_i), .alu_wdata_i(alu_wdata_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
        .stall_o(stall_o), .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .retire_valid_o(retire_valid_o),
        .retire_pc_o(retire_pc_o), .instret_o(instret_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_instret = 64'd0;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] alu;
        logic        rsp;
        logic [63:0] rdata;
        logic        e_stall;
        logic        e_ret;
        logic        e_wen;
        logic [63:0] e_wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; inst_addr_i = '0; rd_waddr_i = '0; reg_wen_i = 1'b0;
        is_load_i = 1'b0; load_funct3_i = '0; load_offset_i = '0; alu_wdata_i = '0;
        mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    endtask

    task automatic drive_inst(input logic [63:0] pc, input logic [4:0] rd, input logic wen,
                              input logic ld, input logic [2:0] f3, input logic [2:0] off,
                              input logic [63:0] alu);
        valid_i = 1'b1; inst_addr_i = pc; rd_waddr_i = rd; reg_wen_i = wen;
        is_load_i = ld; load_funct3_i = f3; load_offset_i = off; alu_wdata_i = alu;
    endtask

    task automatic check_retire(input string tag, input logic e_ret, input logic e_wen,
                                input logic [4:0] e_rd, input logic [63:0] e_wdata,
                                input logic [63:0] e_pc);
        chk({tag, ".retire_valid"}, {63'd0, retire_valid_o}, {63'd0, e_ret});
        chk({tag, ".rf_wen"}, {63'd0, rf_wen_o}, {63'd0, e_wen});
        if (e_ret) chk({tag, ".retire_pc"}, retire_pc_o, e_pc);
        if (e_wen) begin
            chk({tag, ".rf_waddr"}, {59'd0, rf_waddr_o}, {59'd0, e_rd});
            chk({tag, ".rf_wdata"}, rf_wdata_o, e_wdata);
        end
        chk({tag, ".instret"}, instret_o, exp_instret);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 64'h8000_0000, 5'd5,  1'b1, 1'b0, 3'b000, 3'd0, 64'h1234, 1'b0, 64'h0,
                     1'b0, 1'b1, 1'b1, 64'h1234};
        vecs[1]  = '{1'b1, 64'h8000_0004, 5'd0,  1'b1, 1'b0, 3'b000, 3'd0, 64'hDEAD, 1'b0, 64'h0,
                     1'b0, 1'b1, 1'b0, 64'h0};
        vecs[2]  = '{1'b1, 64'h8000_0008, 5'd6,  1'b1, 1'b1, 3'b000, 3'd3, 64'h0, 1'b1, 64'h0000_0000_8000_0000,
                     1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[3]  = '{1'b1, 64'h8000_000C, 5'd7,  1'b1, 1'b1, 3'b100, 3'd3, 64'h0, 1'b1, 64'h0000_0000_8000_0000,
                     1'b0, 1'b1, 1'b1, 64'h80};
        vecs[4]  = '{1'b0, 64'h8000_0010, 5'd8,  1'b1, 1'b1, 3'b011, 3'd0, 64'h0, 1'b1, 64'h1111_2222_3333_4444,
                     1'b0, 1'b0, 1'b0, 64'h0};
        vecs[5]  = '{1'b1, 64'h8000_0014, 5'd9,  1'b0, 1'b0, 3'b000, 3'd0, 64'h5555, 1'b0, 64'h0,
                     1'b0, 1'b1, 1'b0, 64'h0};
        vecs[6]  = '{1'b1, 64'h8000_0018, 5'd10, 1'b1, 1'b1, 3'b001, 3'd2, 64'h0, 1'b1, 64'h0000_0000_8001_0000,
                     1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
        vecs[7]  = '{1'b1, 64'h8000_001C, 5'd11, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0, 1'b1, 64'h0123_4567_89AB_CDEF,
                     1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[8]  = '{1'b1, 64'h8000_0020, 5'd12, 1'b1, 1'b1, 3'b110, 3'd4, 64'h0, 1'b1, 64'h8765_4321_0000_0000,
                     1'b0, 1'b1, 1'b1, 64'h0000_0000_8765_4321};
        vecs[9]  = '{1'b1, 64'h8000_0024, 5'd13, 1'b1, 1'b1, 3'b111, 3'd0, 64'h0, 1'b1, 64'hFEDC_BA98_7654_3210,
                     1'b0, 1'b1, 1'b1, 64'hFEDC_BA98_7654_3210};
        vecs[10] = '{1'b1, 64'h8000_0028, 5'd14, 1'b1, 1'b1, 3'b101, 3'd6, 64'h0, 1'b1, 64'hBEEF_0000_0000_0000,
                     1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_BEEF};
        vecs[11] = '{1'b1, 64'h8000_002C, 5'd15, 1'b1, 1'b1, 3'b010, 3'd0, 64'h0, 1'b1, 64'h0000_0000_7FFF_FFFF,
                     1'b0, 1'b1, 1'b1, 64'h0000_0000_7FFF_FFFF};

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rf_wen", {63'd0, rf_wen_o}, 64'd0);
        chk("reset.retire_valid", {63'd0, retire_valid_o}, 64'd0);
        chk("reset.instret", instret_o, 64'd0);
        chk("reset.timeout", {63'd0, timeout_o}, 64'd0);
        chk("reset.rf_wdata", rf_wdata_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single-cycle retirements from the vector table.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            valid_i = vecs[i].valid; inst_addr_i = vecs[i].pc; rd_waddr_i = vecs[i].rd;
            reg_wen_i = vecs[i].wen; is_load_i = vecs[i].ld; load_funct3_i = vecs[i].f3;
            load_offset_i = vecs[i].off; alu_wdata_i = vecs[i].alu;
            mem_rsp_valid_i = vecs[i].rsp; mem_rsp_data_i = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d.stall", i), {63'd0, stall_o}, {63'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            if (vecs[i].e_ret) exp_instret = exp_instret + 64'd1;
            check_retire($sformatf("vec%0d", i), vecs[i].e_ret, vecs[i].e_wen, vecs[i].rd,
                         vecs[i].e_wdata, vecs[i].pc);
        end

        // Delayed LW: three stall cycles, response on the fourth.
        @(negedge clk);
        idle_inputs();
        drive_inst(64'h9000_0000, 5'd20, 1'b1, 1'b1, 3'b010, 3'd4, 64'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("dly.stall%0d", c), {63'd0, stall_o}, 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("dly.noret%0d", c), {63'd0, retire_valid_o}, 64'd0);
            @(negedge clk);
            // Upstream is held in hardware; garbage here must be ignored during the wait.
            drive_inst(64'hDEAD_0000, 5'd1, 1'b1, 1'b0, 3'b000, 3'd0, 64'hBAD);
        end
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'h8765_4321_0000_0000;
        #1;
        chk("dly.stall_rsp", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        exp_instret = exp_instret + 64'd1;
        check_retire("dly.ret", 1'b1, 1'b1, 5'd20, 64'hFFFF_FFFF_8765_4321, 64'h9000_0000);
        @(negedge clk);
        idle_inputs();
        drive_inst(64'h9000_0004, 5'd21, 1'b1, 1'b0, 3'b000, 3'd0, 64'hCAFE);
        #1;
        chk("dly.next_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        exp_instret = exp_instret + 64'd1;
        check_retire("dly.next", 1'b1, 1'b1, 5'd21, 64'hCAFE, 64'h9000_0004);

        // Timeout with RSP_TIMEOUT=4: stall for four cycles, fire on the fifth.
        @(negedge clk);
        idle_inputs();
        drive_inst(64'hA000_0000, 5'd22, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to.stall%0d", c), {63'd0, stall_o}, 64'd1);
            chk($sformatf("to.flag_pre%0d", c), {63'd0, timeout_o}, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("to.stall_fire", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        exp_instret = exp_instret + 64'd1;
        check_retire("to.ret", 1'b1, 1'b0, 5'd22, 64'h0, 64'hA000_0000);
        chk("to.flag", {63'd0, timeout_o}, 64'd1);
        @(negedge clk);
        idle_inputs();
        @(posedge clk);
        #1;
        chk("to.after_retire", {63'd0, retire_valid_o}, 64'd0);
        chk("to.sticky", {63'd0, timeout_o}, 64'd1);

        // Reset during WAIT_RSP discards the load; a late response is ignored.
        @(negedge clk);
        drive_inst(64'hB000_0000, 5'd23, 1'b1, 1'b1, 3'b011, 3'd0, 64'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst.stall_wait", {63'd0, stall_o}, 64'd1);
        idle_inputs();
        rst = 1'b0;
        #1;
        exp_instret = 64'd0;
        chk("rst.stall", {63'd0, stall_o}, 64'd0);
        chk("rst.timeout", {63'd0, timeout_o}, 64'd0);
        chk("rst.rf_wdata", rf_wdata_o, 64'd0);
        chk("rst.retire_pc", retire_pc_o, 64'd0);
        check_retire("rst.async", 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("rst.late_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk);
        #1;
        check_retire("rst.late_rsp", 1'b0, 1'b0, 5'd0, 64'h0, 64'h0);
        @(negedge clk);
        idle_inputs();
        drive_inst(64'hC000_0000, 5'd24, 1'b1, 1'b0, 3'b000, 3'd0, 64'h77);
        @(posedge clk);
        #1;
        exp_instret = exp_instret + 64'd1;
        check_retire("rst.after", 1'b1, 1'b1, 5'd24, 64'h77, 64'hC000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage, the consumer end of the MEM/WB pipeline register.
- Takes each instruction leaving MEM/WB and retires it: writes the register-file write port and counts retirements.
- For loads, waits on a data-memory read response, then aligns and extends the returned data.
- Stalls upstream while a load response is outstanding; a timeout guards against a lost response.

Parameters:
- RSP_TIMEOUT, 255, maximum cycles spent in WAIT_RSP before the load is abandoned (1..65535).
- XLEN, 64, datapath width (fixed at 64 for RV64).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  MEM/WB holds a valid instruction this cycle.
- inst_addr_i  in  64  PC of that instruction.
- rd_waddr_i  in  5  destination register.
- reg_wen_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load; write data comes from memory.
- load_funct3_i  in  3  RV64 load funct3.
- load_offset_i  in  3  byte offset of the load within the 64-bit response word.
- alu_wdata_i  in  64  write data for non-loads.
- mem_rsp_valid_i  in  1  memory read response valid.
- mem_rsp_data_i  in  64  raw 64-bit response word.
- stall_o  out  1  hold MEM/WB and earlier stages.
- rf_wen_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  64  register-file write data.
- retire_valid_o  out  1  one instruction retired.
- retire_pc_o  out  64  PC of the retired instruction.
- instret_o  out  64  retired-instruction counter.
- timeout_o  out  1  sticky flag: a load response timed out.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
- Reset values: rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, retire_valid_o=0, retire_pc_o=0, instret_o=0, timeout_o=0, wait counter=0.
- Reset asserted mid-WAIT_RSP: the pending load is discarded; nothing is written or retired.
- All rf_* and retire_* outputs are registered.
- They are asserted for exactly one cycle, the cycle after the retiring edge; otherwise rf_wen_o=0 and retire_valid_o=0.
- Write-address filter: rf_wen_o = reg_wen && (rd != 0); x0 is never written.
- Retirement counting: retire_valid_o and the instret increment occur for every retired instruction, including rd=0 and reg_wen=0.
- instret_o wraps modulo 2^64.
- State IDLE, valid_i=0: nothing happens.
- State IDLE, valid_i=1, is_load_i=0: retire at this edge with wdata=alu_wdata_i.
- State IDLE, valid_i=1, is_load_i=1, mem_rsp_valid_i=1: retire at this edge with wdata=ext(mem_rsp_data_i).
- State IDLE, valid_i=1, is_load_i=1, mem_rsp_valid_i=0: capture rd, wen, pc, funct3 and offset; go to WAIT_RSP; counter=0.
- State WAIT_RSP: inputs valid_i, alu_wdata_i and the other instruction fields are ignored (upstream is held).
- WAIT_RSP, mem_rsp_valid_i=1: retire the captured load with ext(mem_rsp_data_i); go to IDLE.
- WAIT_RSP, no response, counter==RSP_TIMEOUT-1: set timeout_o.
  - retire_valid_o=1 with the captured PC and instret increments.
  - rf_wen_o=0; the load is dropped.
  - Go to IDLE.
- WAIT_RSP, no response, otherwise: counter increments.
- stall_o is combinational and equals 1 when either holds:
  - (IDLE && valid_i && is_load_i && !mem_rsp_valid_i), or
  - (WAIT_RSP && !mem_rsp_valid_i && counter != RSP_TIMEOUT-1).
- stall_o is therefore 0 in the cycle the response arrives or the timeout fires.
- After a stalled load, upstream advances on that same edge and the next instruction is sampled in IDLE on the following cycle.
- mem_rsp_valid_i in IDLE with no valid load is ignored.
- ext(): s = mem_rsp_data_i >> (8*offset), applied by funct3:
  - 000 LB: sign-extend s[7:0].
  - 001 LH: sign-extend s[15:0].
  - 010 LW: sign-extend s[31:0].
  - 011 LD: s.
  - 100 LBU: zero-extend s[7:0].
  - 101 LHU: zero-extend s[15:0].
  - 110 LWU: zero-extend s[31:0].
  - 111: treated as LD.
- Misaligned offsets are not checked; the bytes are taken as shifted.
- timeout_o is cleared only by reset.

Test Plan:
- After reset, ALU op: valid_i=1, rd=5, wen=1, alu_wdata=0x1234, pc=0x80000000 -> next cycle rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0x1234, retire_pc_o=0x80000000, instret_o=1, stall_o=0 throughout.
- x0 suppression: rd=0, wen=1 -> rf_wen_o=0, retire_valid_o=1, instret_o increments.
- Same-cycle load: LB (funct3=000), offset=3, rsp same cycle with data 0x00000000_80000000 -> rf_wdata_o=0xFFFFFFFF_FFFFFF80, no stall.
  - Repeat with LBU -> rf_wdata_o=0x80.
- Delayed load: LW (funct3=010), offset=4, rsp after 3 cycles with data 0x87654321_00000000.
  - stall_o=1 for 3 cycles, then 0 in the response cycle.
  - Next cycle rf_wdata_o=0xFFFFFFFF_87654321.
  - The following ALU instruction retires on the cycle after.
- Timeout: RSP_TIMEOUT=4, load with no response.
  - stall_o high 4 cycles (the IDLE capture cycle plus 3 WAIT_RSP cycles), low on the 5th.
  - timeout_o=1 sticky, retire_valid_o=1, rf_wen_o=0.
- Reset mid-wait: assert rst=0 during WAIT_RSP -> all outputs 0 immediately, state IDLE.
  - A response arriving after reset is released is ignored.
